packet_receiver: RTL and testbench

//  Receive-side packet decoder of the USB host. Consumes the NRZI-decoded, bit-unstuffed serial stream and produces

---
 rtl/usb_pkg.sv | 27 ++
 rtl/crc16_checker.sv | 29 ++
 rtl/packet_receiver.sv | 158 +++++++++++++++
 tb/tb_packet_receiver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB host definitions: PID codes, SYNC pattern, CRC16 constants and
// receiver state types. Imported by the packet receiver and its CRC checker.
package usb_pkg;

  // 4-bit PID field; the wire byte is {~pid, pid}, sent LSB-first.
  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_SOF   = 4'h5,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_t;

  // Window value after seven 0s followed by a 1 (newest bit lands in [7]).
  localparam logic [7:0]  SYNC_PATTERN  = 8'h80;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [1:0] {ST_IDLE, ST_PID, ST_DATA, ST_WAIT_EOP} rx_state_t;
  typedef enum logic [1:0] {HS_ACK, HS_NAK, HS_BAD} hs_kind_t;

endpackage

// File: rtl/crc16_checker.sv
// Serial CRC16 (x^16+x^15+x^2+1), one bit per enabled cycle, data LSB-first.
// Shared by the receive checker and the transmit generator.
// Ports:
//   clock, reset_n : clock, async active-low reset (register cleared to 0)
//   clr            : preset register to FFFF (wins over en)
//   en             : shift in bit_in this cycle
//   bit_in         : serial data bit
//   crc            : current register contents
module crc16_checker
  import usb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[15];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  crc <= '0;
    else if (clr)  crc <= CRC16_PRESET;
    else if (en)   crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/packet_receiver.sv
// Receive-side USB packet decoder: SYNC hunt, PID check, DATA0 payload
// capture with CRC16 check, ACK/NAK handshake detection.
// Ports:
//   clock, reset_n   : clock, async active-low reset
//   rx_en            : listen enable, low forces IDLE without a result
//   bit_in/bit_valid : unstuffed serial bit and its strobe
//   eop              : end-of-packet strobe (wins over a same-cycle bit)
//   rec_start        : level, SYNC match through the result pulse cycle
//   rec_DATA0        : pulse, DATA0 packet ended; data_valid qualifies it
//   data_rec         : payload, [0] = first bit on wire, held until next SYNC
//   rec_ACK/rec_NAK  : pulse, clean handshake ended
//   pid_err          : pulse, bad/unsupported PID or short/long handshake
module packet_receiver
  import usb_pkg::*;
#(
  parameter int          DATA_BITS   = 64,
  parameter logic [15:0] CRC_RESIDUE = CRC16_RESIDUE
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_en,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 eop,
  output logic                 rec_start,
  output logic                 rec_DATA0,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_rec,
  output logic                 rec_ACK,
  output logic                 rec_NAK,
  output logic                 pid_err
);

  localparam int CNT_W = $clog2(DATA_BITS + 18);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_PAY  = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(DATA_BITS + 16);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_BITS + 17);
  localparam logic [CNT_W-1:0] CNT_PID  = CNT_W'(7);

  rx_state_t        state;
  hs_kind_t         kind;
  logic [7:0]       shreg;
  logic [7:0]       win_next;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      crc;
  logic             crc_en;
  logic             crc_clr;

  assign win_next = {bit_in, shreg[7:1]};
  // CRC sits at preset outside DATA so it is ready on the first payload bit.
  assign crc_clr  = (state != ST_DATA);
  assign crc_en   = rx_en && (state == ST_DATA) && bit_valid && !eop;

  crc16_checker u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .bit_in  (bit_in),
    .crc     (crc)
  );

  // The window rests at all-ones (idle line) so a lone 1 after reset or after
  // a packet cannot alias SYNC; seven real 0s are always needed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      kind       <= HS_ACK;
      shreg      <= '1;
      cnt        <= '0;
      data_rec   <= '0;
      rec_start  <= 1'b0;
      rec_DATA0  <= 1'b0;
      data_valid <= 1'b0;
      rec_ACK    <= 1'b0;
      rec_NAK    <= 1'b0;
      pid_err    <= 1'b0;
    end else begin
      rec_DATA0  <= 1'b0;
      data_valid <= 1'b0;
      rec_ACK    <= 1'b0;
      rec_NAK    <= 1'b0;
      pid_err    <= 1'b0;
      if (!rx_en) begin
        state     <= ST_IDLE;
        rec_start <= 1'b0;
        shreg     <= '1;
        cnt       <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            rec_start <= 1'b0;
            if (bit_valid && !eop) begin
              shreg <= win_next;
              if (win_next == SYNC_PATTERN) begin
                state     <= ST_PID;
                rec_start <= 1'b1;
                data_rec  <= '0;
                cnt       <= '0;
              end
            end
          end
          ST_PID: begin
            if (eop) begin
              pid_err <= 1'b1;
              state   <= ST_IDLE;
              shreg   <= '1;
            end else if (bit_valid) begin
              shreg <= win_next;
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_PID) begin
                cnt   <= '0;
                state <= ST_WAIT_EOP;
                kind  <= HS_BAD;
                if (win_next[7:4] == ~win_next[3:0]) begin
                  case (win_next[3:0])
                    PID_DATA0: state <= ST_DATA;
                    PID_ACK:   kind  <= HS_ACK;
                    PID_NAK:   kind  <= HS_NAK;
                    default:   kind  <= HS_BAD;
                  endcase
                end
              end
            end
          end
          ST_DATA: begin
            if (eop) begin
              rec_DATA0  <= 1'b1;
              data_valid <= (cnt == CNT_GOOD) && (crc == CRC_RESIDUE);
              state      <= ST_IDLE;
              shreg      <= '1;
            end else if (bit_valid) begin
              if (cnt < CNT_PAY) data_rec[cnt[IDX_W-1:0]] <= bit_in;
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end
          end
          ST_WAIT_EOP: begin
            if (eop) begin
              case (kind)
                HS_ACK:  rec_ACK <= 1'b1;
                HS_NAK:  rec_NAK <= 1'b1;
                default: pid_err <= 1'b1;
              endcase
              state <= ST_IDLE;
              shreg <= '1;
            end else if (bit_valid) begin
              // A handshake carries nothing after its PID.
              kind <= HS_BAD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: DATA0 good/bad CRC and length, ACK/NAK,
// PID errors, leading noise, rx_en abort and mid-packet reset.
module tb_packet_receiver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        eop = 1'b0;
  logic        rec_start, rec_DATA0, data_valid, rec_ACK, rec_NAK, pid_err;
  logic [63:0] data_rec;

  int nvec = 0;
  int nerr = 0;

  localparam logic [63:0] PAY = 64'hDEADBEEF_01234567;

  packet_receiver dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_en      (rx_en),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .eop        (eop),
    .rec_start  (rec_start),
    .rec_DATA0  (rec_DATA0),
    .data_valid (data_valid),
    .data_rec   (data_rec),
    .rec_ACK    (rec_ACK),
    .rec_NAK    (rec_NAK),
    .pid_err    (pid_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // USB CRC16 in the common reflected software form (poly A001, LSB-first),
  // returned already inverted; transmitted LSB-first.
  function automatic logic [15:0] usb_crc(input logic [63:0] d);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < 64; i++)
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    return ~r;
  endfunction

  // One bit strobe, then one idle cycle carrying the opposite bit value.
  task automatic send_bit(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clock); #1;
    bit_valid = 1'b0; bit_in = ~b;
    @(posedge clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  // eop strobe; on return the result pulse is visible.
  task automatic send_eop(input logic with_bit);
    eop = 1'b1; bit_valid = with_bit; bit_in = 1'b1;
    @(posedge clock); #1;
    eop = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // SYNC + DATA0 PID + first nbits of {crc, payload} (extra bits are 0).
  task automatic send_data(input logic [63:0] pay, input logic [15:0] c, input int nbits);
    logic [79:0] s;
    s = {c, pay};
    send_byte(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < nbits; i++) send_bit(i < 80 ? s[i] : 1'b0);
  endtask

  logic [15:0] crc_good;

  initial begin
    crc_good = usb_crc(PAY);
    #12;
    chk("reset outputs", {rec_start, rec_DATA0, data_valid, rec_ACK, rec_NAK, pid_err}, 6'b0);
    chk("reset data_rec", data_rec, 64'h0);
    @(posedge clock); #1;
    reset_n = 1'b1; rx_en = 1'b1;
    idle(2);

    // Good DATA0 packet
    send_data(PAY, crc_good, 80);
    chk("d0 start before eop", rec_start, 1'b1);
    send_eop(1'b0);
    chk("d0 pulses", {rec_DATA0, data_valid, rec_ACK, rec_NAK, pid_err}, 5'b11000);
    chk("d0 payload", data_rec, PAY);
    chk("d0 start in pulse", rec_start, 1'b1);
    idle(1);
    chk("d0 pulse single", {rec_DATA0, data_valid}, 2'b00);
    chk("d0 start drop", rec_start, 1'b0);

    // Payload bit 17 flipped, original CRC
    send_data(PAY ^ 64'h0000_0000_0002_0000, crc_good, 80);
    send_eop(1'b0);
    chk("flip pulses", {rec_DATA0, data_valid}, 2'b10);
    chk("flip payload", data_rec, 64'hDEADBEEF_01214567);
    idle(2);

    // ACK then NAK (NAK eop collides with a bit, which is discarded)
    send_byte(8'h80);
    chk("ack start", rec_start, 1'b1);
    send_byte(8'hD2);
    chk("ack start after pid", rec_start, 1'b1);
    send_eop(1'b0);
    chk("ack pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0100);
    idle(1);
    chk("ack single", rec_ACK, 1'b0);
    send_byte(8'h80);
    send_byte(8'h5A);
    chk("nak start", rec_start, 1'b1);
    send_eop(1'b1);
    chk("nak pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0010);
    idle(1);
    chk("nak single", rec_NAK, 1'b0);

    // Bad complement, unsupported PID, long handshake, short packet
    send_byte(8'h80); send_byte(8'hC2); send_eop(1'b0);
    chk("badcomp pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0001);
    idle(1);
    send_byte(8'h80); send_byte(8'h69); send_eop(1'b0);
    chk("in pid pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0001);
    idle(1);
    send_byte(8'h80); send_byte(8'hD2); send_bit(1'b0); send_eop(1'b0);
    chk("ack+bit pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0001);
    idle(1);
    send_byte(8'h80); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_eop(1'b0);
    chk("short pulses", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0001);
    idle(1);

    // Length errors
    send_data(PAY, crc_good, 70); send_eop(1'b0);
    chk("len70 pulses", {rec_DATA0, data_valid}, 2'b10);
    idle(1);
    send_data(PAY, crc_good, 81); send_eop(1'b0);
    chk("len81 pulses", {rec_DATA0, data_valid}, 2'b10);
    chk("len81 payload", data_rec, PAY);
    idle(1);

    // Leading noise before SYNC
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    send_data(PAY, crc_good, 80); send_eop(1'b0);
    chk("noise pulses", {rec_DATA0, data_valid}, 2'b11);
    chk("noise payload", data_rec, PAY);
    idle(1);

    // rx_en dropped at payload bit 30
    send_data(PAY, crc_good, 30);
    rx_en = 1'b0;
    @(posedge clock); #1;
    chk("rxen start", rec_start, 1'b0);
    chk("rxen pulses", {rec_DATA0, data_valid, rec_ACK, rec_NAK, pid_err}, 5'b0);
    chk("rxen data held", data_rec, PAY & 64'h0000_0000_3FFF_FFFF);
    rx_en = 1'b1;
    send_eop(1'b0);
    chk("rxen late eop", {rec_DATA0, rec_ACK, rec_NAK, pid_err}, 4'b0);
    idle(1);

    // Reset mid-DATA, then a good packet
    send_data(PAY, crc_good, 20);
    reset_n = 1'b0;
    #2;
    chk("midrst outputs", {rec_start, rec_DATA0, data_valid, rec_ACK, rec_NAK, pid_err}, 6'b0);
    chk("midrst data_rec", data_rec, 64'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(1);
    send_data(PAY, crc_good, 80); send_eop(1'b0);
    chk("postrst pulses", {rec_DATA0, data_valid, pid_err}, 3'b110);
    chk("postrst payload", data_rec, PAY);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
